// File: rtl/vend_pkg.sv
// vend_pkg: state encodings and saturating add shared by the vending-session controller.
package vend_pkg;
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } vend_state_e;
   // Widths up to 32 bits; the 33-bit sum keeps the carry so the clamp never sees a wrapped value.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [32:0] s;
      logic [32:0] m;
      s = {1'b0, a} + {1'b0, b};
      m = (33'd1 << w) - 33'd1;
      return (s > m) ? m[31:0] : s[31:0];
   endfunction
endpackage

// File: rtl/vend_credit_acc.sv
// vend_credit_acc: saturating credit accumulator with synchronous clear and add-enable.
module vend_credit_acc
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8,
   parameter int COIN_W   = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                add,
   input  logic [COIN_W-1:0]   coin,
   output logic [CREDIT_W-1:0] credit,
   output logic [CREDIT_W-1:0] credit_next
);
   always_comb begin
      credit_next = add ? CREDIT_W'(sat_add(32'(credit), 32'(coin), CREDIT_W)) : credit;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) credit <= '0;
      else credit <= clr ? '0 : credit_next;
   end
endmodule

// File: rtl/vend_session_fsm.sv
// vend_session_fsm: one purchase session -- collect coins, dispense, then hand back change/refund.
// Define VEND_TIMEOUT_EN to abandon COLLECT after TIMEOUT_CYCLES cycles without a coin.
module vend_session_fsm
   import vend_pkg::*;
#(
   parameter int CREDIT_W       = 8,
   parameter int COIN_W         = 6,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [CREDIT_W-1:0] price,
   input  logic                coin_valid,
   input  logic [COIN_W-1:0]   coin_value,
   input  logic                cancel,
   input  logic                change_ack,
   output logic [1:0]          state,
   output logic [CREDIT_W-1:0] credit,
   output logic                dispense,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt
);
   vend_state_e st, st_n;
   logic [CREDIT_W-1:0] price_q, credit_next, amt_n;
   logic timeout;
   vend_credit_acc #(.CREDIT_W(CREDIT_W), .COIN_W(COIN_W)) u_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (st_n == ST_IDLE),
      .add         (st == ST_COLLECT && coin_valid),
      .coin        (coin_value),
      .credit      (credit),
      .credit_next (credit_next)
   );
`ifdef VEND_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] idle_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idle_cnt <= '0;
      else idle_cnt <= (st != ST_COLLECT || coin_valid) ? '0 : idle_cnt + 1'b1;
   end
   assign timeout = st == ST_COLLECT && !coin_valid && idle_cnt == TO_W'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif
   always_comb begin
      st_n  = st;
      amt_n = change_amt;
      case (st)
         ST_IDLE: st_n = start ? ST_COLLECT : ST_IDLE;
         ST_COLLECT:
            if (credit_next >= price_q) st_n = ST_DISPENSE;
            else if (cancel) begin
               st_n  = ST_CHANGE;
               amt_n = credit_next;
            end else if (timeout) begin
               st_n  = (credit != '0) ? ST_CHANGE : ST_IDLE;
               amt_n = credit;
            end
         ST_DISPENSE: begin
            // Entry guarantees credit >= price_q, so any difference is change owed.
            amt_n = credit - price_q;
            st_n  = (credit != price_q) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE:
            if (change_ack) begin
               st_n  = ST_IDLE;
               amt_n = '0;
            end
         default: st_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= ST_IDLE;
         price_q      <= '0;
         dispense     <= 1'b0;
         change_valid <= 1'b0;
         change_amt   <= '0;
      end else begin
         st           <= st_n;
         price_q      <= (st == ST_IDLE && start) ? price : price_q;
         dispense     <= st_n == ST_DISPENSE;
         change_valid <= st_n == ST_CHANGE;
         change_amt   <= amt_n;
      end
   end
   assign state = st;
endmodule

// File: tb/tb_vend_session_fsm.sv
// tb_vend_session_fsm: directed self-checking bench for vend_session_fsm (CREDIT_W=8, COIN_W=6, TIMEOUT_CYCLES=8).
module tb_vend_session_fsm;
   logic       clk = 1'b0;
   logic       rst_n, start, coin_valid, cancel, change_ack;
   logic [7:0] price;
   logic [5:0] coin_value;
   logic [1:0] state;
   logic [7:0] credit, change_amt;
   logic       dispense, change_valid;
   int checks = 0;
   int errors = 0;

   vend_session_fsm #(.CREDIT_W(8), .COIN_W(6), .TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .price        (price),
      .coin_valid   (coin_valid),
      .coin_value   (coin_value),
      .cancel       (cancel),
      .change_ack   (change_ack),
      .state        (state),
      .credit       (credit),
      .dispense     (dispense),
      .change_valid (change_valid),
      .change_amt   (change_amt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic coin(input logic [5:0] v);
      coin_valid = 1'b1;
      coin_value = v;
      step();
      coin_valid = 1'b0;
      coin_value = '0;
   endtask

   task automatic begin_session(input logic [7:0] p);
      price = p;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; coin_valid = 1'b0; cancel = 1'b0; change_ack = 1'b0;
      price = '0; coin_value = '0;
      #12;
      chk("rst_state", 32'(state), 0);
      chk("rst_credit", 32'(credit), 0);
      chk("rst_disp", 32'(dispense), 0);
      chk("rst_cv", 32'(change_valid), 0);
      chk("rst_amt", 32'(change_amt), 0);
      rst_n = 1'b1;
      step();
      // coins in IDLE are ignored
      coin(6'd7);
      chk("idle_coin_credit", 32'(credit), 0);
      chk("idle_coin_state", 32'(state), 0);
      // 1: async reset mid-COLLECT
      begin_session(8'd25);
      chk("t1_collect", 32'(state), 1);
      coin(6'd10);
      chk("t1_credit", 32'(credit), 10);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_async_state", 32'(state), 0);
      chk("t1_async_credit", 32'(credit), 0);
      chk("t1_async_disp", 32'(dispense), 0);
      chk("t1_async_cv", 32'(change_valid), 0);
      rst_n = 1'b1;
      step();
      // 2: 25 price, 30 paid, change 5
      begin_session(8'd25);
      coin(6'd10);
      coin(6'd10);
      chk("t2_mid_state", 32'(state), 1);
      coin(6'd10);
      chk("t2_disp_state", 32'(state), 2);
      chk("t2_disp", 32'(dispense), 1);
      chk("t2_credit", 32'(credit), 30);
      step();
      chk("t2_chg_state", 32'(state), 3);
      chk("t2_disp_once", 32'(dispense), 0);
      chk("t2_cv", 32'(change_valid), 1);
      chk("t2_amt", 32'(change_amt), 5);
      step();
      chk("t2_amt_held", 32'(change_amt), 5);
      chk("t2_cv_held", 32'(change_valid), 1);
      change_ack = 1'b1; start = 1'b1;
      step();
      change_ack = 1'b0; start = 1'b0;
      chk("t2_idle", 32'(state), 0);
      chk("t2_credit0", 32'(credit), 0);
      chk("t2_cv0", 32'(change_valid), 0);
      chk("t2_amt0", 32'(change_amt), 0);
      step();
      chk("t2_start_with_ack_ignored", 32'(state), 0);
      // 3: exact payment
      begin_session(8'd25);
      coin(6'd20);
      coin(6'd5);
      chk("t3_disp_state", 32'(state), 2);
      chk("t3_disp", 32'(dispense), 1);
      step();
      chk("t3_idle", 32'(state), 0);
      chk("t3_cv", 32'(change_valid), 0);
      chk("t3_amt", 32'(change_amt), 0);
      chk("t3_credit", 32'(credit), 0);
      // 4: cancel with a coin in the same cycle
      begin_session(8'd25);
      coin(6'd10);
      cancel = 1'b1;
      coin(6'd5);
      cancel = 1'b0;
      chk("t4_state", 32'(state), 3);
      chk("t4_amt", 32'(change_amt), 15);
      chk("t4_cv", 32'(change_valid), 1);
      chk("t4_disp", 32'(dispense), 0);
      chk("t4_credit", 32'(credit), 15);
      change_ack = 1'b1;
      step();
      change_ack = 1'b0;
      chk("t4_idle", 32'(state), 0);
      // 5: saturation at 255
      begin_session(8'd255);
      for (int i = 0; i < 4; i++) coin(6'd63);
      chk("t5_credit252", 32'(credit), 252);
      chk("t5_collect", 32'(state), 1);
      coin(6'd63);
      chk("t5_sat", 32'(credit), 255);
      chk("t5_disp_state", 32'(state), 2);
      chk("t5_disp", 32'(dispense), 1);
      step();
      chk("t5_idle", 32'(state), 0);
      chk("t5_amt", 32'(change_amt), 0);
      chk("t5_cv", 32'(change_valid), 0);
      // price 0 dispenses on the first COLLECT cycle
      begin_session(8'd0);
      chk("p0_collect", 32'(state), 1);
      step();
      chk("p0_disp", 32'(dispense), 1);
      step();
      chk("p0_idle", 32'(state), 0);
      // 6: inactivity timeout
      begin_session(8'd25);
      coin(6'd10);
      for (int i = 0; i < 7; i++) step();
      chk("t6_before_timeout", 32'(state), 1);
      step();
`ifdef VEND_TIMEOUT_EN
      chk("t6_timeout_state", 32'(state), 3);
      chk("t6_timeout_amt", 32'(change_amt), 10);
`else
      chk("t6_no_timeout", 32'(state), 1);
      chk("t6_credit_kept", 32'(credit), 10);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk("t6_cancel_amt", 32'(change_amt), 10);
`endif
      change_ack = 1'b1;
      step();
      change_ack = 1'b0;
      chk("t6_idle", 32'(state), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
